cbs_tx_scheduler: RTL

- Credit-based shaper (IEEE 802.1Qav style) egress scheduler for one switch port.
- Keeps a signed credit counter per traffic-class queue and selects one eligible queue by strict priority.
- Grants the egress MAC via a valid/ready handshake, then holds the grant until the frame completes.
- Slopes and limits come from the port's CBS register block as static configuration.

---
 rtl/cbs_pkg.sv | 42 ++++
 rtl/cbs_credit_counter.sv | 64 ++++++
 rtl/cbs_tx_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cbs_pkg.sv
// Shared types and helpers for the credit-based shaper egress scheduler.
package cbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_TX    = 2'd2
  } state_t;

  // Priority pick works on a fixed-width vector; callers zero-extend their request mask.
  localparam int PICK_W     = 32;
  localparam int PICK_IDX_W = 5;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  function automatic pick_t pick_highest(input logic [PICK_W-1:0] vec);
    pick_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < PICK_W; i++) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = PICK_IDX_W'(i);
      end
    end
    return r;
  endfunction

  // Most negative two's-complement value a credit counter of the given width may hold.
  function automatic longint credit_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Most positive two's-complement value a credit counter of the given width may hold.
  function automatic longint credit_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

endpackage

// File: rtl/cbs_credit_counter.sv
// One traffic-class credit register: idle-slope accrual clamped to hi_credit,
// send-slope drain saturating at the most negative value, reset to 0 when idle.
module cbs_credit_counter
  import cbs_pkg::*;
#(
  parameter int SLOPE_W  = 16,
  parameter int CREDIT_W = 24
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_en,
  input  logic                       i_req,
  input  logic                       i_tx,
  input  logic [SLOPE_W-1:0]         i_idle_slope,
  input  logic [SLOPE_W-1:0]         i_send_slope,
  input  logic signed [CREDIT_W-1:0] i_hi_credit,
  output logic signed [CREDIT_W-1:0] o_credit
);

  // Wide enough that credit +/- any slope never overflows before saturation.
  localparam int AW = ((CREDIT_W > SLOPE_W) ? CREDIT_W : SLOPE_W) + 2;
  localparam logic signed [AW-1:0] L_MIN = AW'(credit_min(CREDIT_W));
  localparam logic signed [AW-1:0] L_MAX = AW'(credit_max(CREDIT_W));

  logic signed [CREDIT_W-1:0] r_credit;
  logic signed [AW-1:0]       w_cur;
  logic signed [AW-1:0]       w_hi;
  logic signed [AW-1:0]       w_sum;
  logic signed [AW-1:0]       w_diff;
  logic signed [AW-1:0]       w_next;
  logic                       w_neg;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cur  = AW'(r_credit);
    w_hi   = AW'(i_hi_credit);
    w_sum  = w_cur + $signed(AW'(i_idle_slope));
    w_diff = w_cur - $signed(AW'(i_send_slope));
    w_neg  = r_credit[CREDIT_W-1];
    w_next = w_cur;

    if (!i_en) begin
      w_next = '0;
    end else if (i_tx) begin
      w_next = (w_diff < L_MIN) ? L_MIN : w_diff;
    end else if (i_req || w_neg) begin
      w_next = (w_sum > w_hi) ? w_hi : w_sum;
      if (w_next > L_MAX) w_next = L_MAX;
    end else if (w_cur > 0) begin
      w_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_credit <= '0;
    end else begin
      r_credit <= CREDIT_W'(w_next);
    end
  end

  assign o_credit = r_credit;

endmodule

// File: rtl/cbs_tx_scheduler.sv
// Credit-based shaper egress scheduler: strict-priority pick among credit-eligible
// queues, valid/ready grant to the MAC, grant held until tx_done.
// Optional per-queue grant counters: define CBS_TX_SCHEDULER_STATS_EN.
module cbs_tx_scheduler
  import cbs_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int SLOPE_W    = 16,
  parameter int CREDIT_W   = 24,
  parameter int QID_W      = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_QUEUES-1:0]          q_req,
  input  logic [NUM_QUEUES-1:0]          cbs_en,
  input  logic [NUM_QUEUES*SLOPE_W-1:0]  idle_slope,
  input  logic [NUM_QUEUES*SLOPE_W-1:0]  send_slope,
  input  logic [NUM_QUEUES*CREDIT_W-1:0] hi_credit,
  output logic                           grant_valid,
  output logic [QID_W-1:0]               grant_queue,
  input  logic                           grant_ready,
  input  logic                           tx_done,
  output logic [NUM_QUEUES*CREDIT_W-1:0] credit,
  output logic                           busy
`ifdef CBS_TX_SCHEDULER_STATS_EN
  ,
  input  logic                           stats_clear,
  output logic [NUM_QUEUES*32-1:0]       grant_count
`endif
);

  state_t                     r_state;
  logic                       r_grant_valid;
  logic [QID_W-1:0]           r_grant_queue;
  logic                       r_busy;

  logic [NUM_QUEUES-1:0]      w_elig;
  logic signed [CREDIT_W-1:0] w_credit [NUM_QUEUES];
  pick_t                      w_pick;
  logic [QID_W-1:0]           w_pick_q;
  logic                       w_accept;

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_q
    logic w_tx;

    // OFFER is not transmitting: only the TX state drains the granted queue.
    assign w_tx = (r_state == ST_TX) && (r_grant_queue == QID_W'(gi));

    cbs_credit_counter #(
      .SLOPE_W  (SLOPE_W),
      .CREDIT_W (CREDIT_W)
    ) u_credit (
      .clk          (clk),
      .rstn         (rstn),
      .i_en         (cbs_en[gi]),
      .i_req        (q_req[gi]),
      .i_tx         (w_tx),
      .i_idle_slope (idle_slope[gi*SLOPE_W +: SLOPE_W]),
      .i_send_slope (send_slope[gi*SLOPE_W +: SLOPE_W]),
      .i_hi_credit  (hi_credit[gi*CREDIT_W +: CREDIT_W]),
      .o_credit     (w_credit[gi])
    );

    assign credit[gi*CREDIT_W +: CREDIT_W] = w_credit[gi];
    assign w_elig[gi] = q_req[gi] && (!cbs_en[gi] || !w_credit[gi][CREDIT_W-1]);
  end

  assign w_pick   = pick_highest(PICK_W'(w_elig));
  assign w_pick_q = QID_W'(w_pick.idx);
  assign w_accept = (r_state == ST_OFFER) && grant_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_queue <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick.found) begin
            r_grant_queue <= w_pick_q;
            r_grant_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (grant_ready) begin
            r_grant_valid <= 1'b0;
            r_state       <= ST_TX;
          end
        end
        ST_TX: begin
          if (tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_queue = r_grant_queue;
  assign busy        = r_busy;

`ifdef CBS_TX_SCHEDULER_STATS_EN
  logic [31:0] r_grant_count [NUM_QUEUES];

  always_ff @(posedge clk) begin
    // NOTE: the counter array is small and software-visible, so it is reset like any register.
    if (!rstn || stats_clear) begin
      for (int i = 0; i < NUM_QUEUES; i++) r_grant_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (w_accept && (r_grant_queue == QID_W'(i))) begin
          r_grant_count[i] <= r_grant_count[i] + 32'd1;
        end
      end
    end
  end

  for (genvar gc = 0; gc < NUM_QUEUES; gc++) begin : g_cnt
    assign grant_count[gc*32 +: 32] = r_grant_count[gc];
  end
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule
